// File: rtl/register_bank.sv
// register_bank: DEPTH x WIDTH edge-triggered word store with a registered
// read port (rd_valid strobe) and a one-word-per-cycle bulk clear sweep.
// Optional feature macro: REGISTER_BANK_PARITY_EN adds one even-parity bit
// per word, an err_inject hook on store and a parity_err flag on reads.
module register_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     store,
  input  logic                     load,
  input  logic                     clear,
  input  logic                     err_inject,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     parity_err
);

  localparam int AW = $clog2(DEPTH);
`ifdef REGISTER_BANK_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  // Depth widened by one bit so an out-of-range address compares correctly
  // even when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [MW-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [MW-1:0]    wdata;
  logic [MW-1:0]    store_word;
  logic [MW-1:0]    rword;
  logic             in_range;

  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign rword    = in_range ? mem_q[addr] : '0;

`ifdef REGISTER_BANK_PARITY_EN
  // Even parity over the data; err_inject flips it so a later read flags it.
  assign store_word = {(^data) ^ err_inject, data};
`else
  logic unused_err_inject;
  assign unused_err_inject = err_inject;
  assign store_word        = data;
`endif

  // Next-state, write-port and read-port selection for the IDLE/CLEAR FSM.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    we         = 1'b0;
    waddr      = addr;
    wdata      = store_word;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          // clear takes priority: any store/load in this cycle is dropped.
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          we = store && in_range;
          if (load) begin
            // Reads the pre-edge word, giving read-before-write on a collision.
            rd_valid_d = 1'b1;
            rd_data_d  = rword[WIDTH-1:0];
          end
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, sweep counter and registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Word storage: one write per cycle from either a store or the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the storage array is reset because reset must leave every word
    // zero; this forces flops rather than a RAM macro, which is intended here.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

`ifdef REGISTER_BANK_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Parity check on an accepted load; out-of-range reads see an all-zero word.
  always_comb begin
    parity_err_d = 1'b0;
    if (state_q == IDLE && !clear && load)
      parity_err_d = rword[WIDTH] ^ (^rword[WIDTH-1:0]);
  end

  // Parity flag register, aligned with rd_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed bench for register_bank. A DEPTH=16 instance is
// checked through a scoreboard of expected read words; a DEPTH=10 instance
// covers out-of-range addressing.
module tb_register_bank;

  localparam int D   = 16;
  localparam int D10 = 10;
`ifdef REGISTER_BANK_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] data;
  logic [3:0] addr;
  logic       store, load, clear, err_inject;
  logic [7:0] rd_data;
  logic       rd_valid, busy, parity_err;

  logic [7:0] t_data;
  logic [3:0] t_addr;
  logic       t_store, t_load, t_clear, t_err_inject;
  logic [7:0] t_rd_data;
  logic       t_rd_valid, t_busy, t_parity_err;

  register_bank #(.WIDTH(8), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .store(store),
    .load(load), .clear(clear), .err_inject(err_inject), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .parity_err(parity_err)
  );

  register_bank #(.WIDTH(8), .DEPTH(D10)) dut10 (
    .clk(clk), .rst_n(rst_n), .data(t_data), .addr(t_addr), .store(t_store),
    .load(t_load), .clear(t_clear), .err_inject(t_err_inject),
    .rd_data(t_rd_data), .rd_valid(t_rd_valid), .busy(t_busy),
    .parity_err(t_parity_err)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_mem [D];
  logic       m_err [D];
  int         m_busy;
  logic       m_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_mem[i] = 8'h00;
      m_err[i] = 1'b0;
    end
    m_busy  = 0;
    m_valid = 1'b0;
    sb.delete();
  endtask

  // One clock of stimulus on the DEPTH=16 instance, then scoreboard checks.
  task automatic cyc(input logic st, input logic ld, input logic clr,
                     input logic [7:0] d, input logic [3:0] a, input logic ei = 1'b0);
    exp_t e;
    @(negedge clk);
    store = st; load = ld; clear = clr; data = d; addr = a; err_inject = ei;
    @(posedge clk);
    m_valid = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (clr) begin
      m_busy = D;
      for (int i = 0; i < D; i++) begin
        m_mem[i] = 8'h00;
        m_err[i] = 1'b0;
      end
    end else begin
      if (ld) begin
        sb.push_back('{data: m_mem[a], perr: m_err[a]});
        m_valid = 1'b1;
      end
      if (st) begin
        m_mem[a] = d;
        m_err[a] = PAR_EN & ei;
      end
    end
    #1;
    check("rd_valid", rd_valid, m_valid);
    check("busy", busy, m_busy > 0);
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        n_fail++;
        $error("FAIL sb_underflow: observed rd_valid 1 expected no pending read");
      end else begin
        e = sb.pop_front();
        check("rd_data", rd_data, e.data);
        check("parity_err", parity_err, e.perr);
      end
    end else begin
      check("parity_idle", parity_err, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  // Reset asserted mid-cycle; outputs must drop without waiting for an edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_parity_err", parity_err, 1'b0);
    model_reset();
    @(negedge clk);
    store = 1'b0; load = 1'b0; clear = 1'b0; err_inject = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic cyc10(input logic st, input logic ld, input logic [7:0] d, input logic [3:0] a);
    @(negedge clk);
    t_store = st; t_load = ld; t_data = d; t_addr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    store = 1'b0; load = 1'b0; clear = 1'b0; err_inject = 1'b0;
    data = 8'h00; addr = 4'h0;
    t_store = 1'b0; t_load = 1'b0; t_clear = 1'b0; t_err_inject = 1'b0;
    t_data = 8'h00; t_addr = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Dirty the bank, then reset mid-cycle and read every word back as zero.
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, 1'b0, 8'hE0 | 8'(i), 4'(i));
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'd4);
    do_reset();
    for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'(i));

    // Write then read; same-cycle store/load returns the old word.
    cyc(1'b1, 1'b0, 1'b0, 8'hA5, 4'd3);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'd3);
    cyc(1'b1, 1'b1, 1'b0, 8'h3C, 4'd3);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'd3);
    idle(1);

    // Random fill and back-to-back readback.
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 4'(i));
    for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'(D - 1 - i));

    // Fill with 0xFF, clear; stores/loads/re-clears during the sweep are ignored.
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, 1'b0, 8'hFF, 4'(i));
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 4'd0);
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b1, (i == 5), 8'h99, 4'(i));
    for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'(i));

    // clear beats a same-cycle store and load.
    cyc(1'b1, 1'b0, 1'b0, 8'h22, 4'd5);
    cyc(1'b1, 1'b1, 1'b1, 8'h11, 4'd5);
    idle(D);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'd5);
    idle(1);

    // Reset seven cycles into a sweep.
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, 1'b0, 8'hC3, 4'(i));
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 4'd0);
    idle(7);
    do_reset();
    for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'(i));

    // Parity: injected error flagged only when the feature is built in.
    cyc(1'b1, 1'b0, 1'b0, 8'h07, 4'd2, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'd2);
    cyc(1'b1, 1'b0, 1'b0, 8'h07, 4'd2, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 4'd2);
    idle(1);

    // DEPTH=10: an out-of-range store changes nothing, an out-of-range load reads 0.
    cyc10(1'b1, 1'b0, 8'h5A, 4'd9);
    cyc10(1'b1, 1'b0, 8'h77, 4'd12);
    cyc10(1'b0, 1'b1, 8'h00, 4'd12);
    check("oor_rd_valid", t_rd_valid, 1'b1);
    check("oor_rd_data", t_rd_data, 8'h00);
    for (int i = 0; i < D10; i++) begin
      cyc10(1'b0, 1'b1, 8'h00, 4'(i));
      check("d10_rd_valid", t_rd_valid, 1'b1);
      check("d10_rd_data", t_rd_data, (i == 9) ? 32'h5A : 32'h00);
    end
    cyc10(1'b0, 1'b0, 8'h00, 4'd0);
    check("d10_valid_drop", t_rd_valid, 1'b0);
    check("d10_hold", t_rd_data, 8'h5A);
    check("d10_busy", t_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised, clocked word memory: the next generation of the team's byte-wide latch store. Holds DEPTH words of WIDTH bits in edge-triggered registers, with addressed writes, a registered read port with a valid strobe, and a sequenced bulk clear. It is the general-purpose storage element for datapath and register-file use across the design.

## Interface

- WIDTH, 8: data word width in bits (≥1).
- DEPTH, 16: number of words (≥2; need not be a power of two).
- AW (localparam): address width, $clog2(DEPTH).

Ports:

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data  in  WIDTH  write data.
- addr  in  AW  word address, shared by store and load.
- store  in  1  write strobe; writes data to addr at the clock edge.
- load  in  1  read strobe.
- clear  in  1  starts a bulk clear of every word.
- err_inject  in  1  with store, corrupts the stored parity bit (PARITY_EN only).
- rd_data  out  WIDTH  read data, registered.
- rd_valid  out  1  one-cycle pulse marking rd_data as valid.
- busy  out  1  high while a clear sweep is in progress.
- parity_err  out  1  parity mismatch on the current read; qualified by rd_valid.

## Operation

- Reset (rst_n low, asynchronous):
  - All words are set to 0.
  - rd_data = 0, rd_valid = 0, busy = 0, parity_err = 0.
  - FSM goes to IDLE and the sweep counter goes to 0.
- FSM states: IDLE, CLEAR.
  - IDLE + clear=1 → CLEAR, with the sweep counter at 0.
  - In CLEAR, one word is zeroed per cycle, at the counter's address, and the counter increments.
  - CLEAR + counter == DEPTH-1 → IDLE, after that word is zeroed.
  - clear asserted while in CLEAR is ignored; the sweep does not restart.
- store in IDLE:
  - mem[addr] ← data.
  - If addr ≥ DEPTH, the write is dropped and no word changes.
- load in IDLE:
  - rd_data ← mem[addr] and rd_valid ← 1 on the same edge.
  - If addr ≥ DEPTH, rd_data ← 0 and rd_valid ← 1.
  - Without load, rd_valid ← 0 and rd_data holds its last value.
- Store and load on the same address in the same cycle: read-before-write. rd_data returns the old word, and the new word is visible to the next load.
- Store or load together with clear in IDLE: clear wins.
  - store is dropped.
  - load is dropped: no rd_valid.
- While busy = 1, store and load are ignored. rd_valid stays 0.
- Reset during CLEAR: immediate return to IDLE with all words 0.

## Timing

- Write latency: 1 edge. Data written at edge k is readable by a load sampled at edge k+1.
- Read latency: 1 cycle. load sampled at edge k gives rd_data/rd_valid valid after edge k; rd_valid is high for exactly that one cycle.
- Back-to-back loads produce back-to-back rd_valid pulses, with no bubble.
- Clear duration:
  - busy rises after the edge that samples clear and stays high for exactly DEPTH cycles.
  - The first load accepted is at the edge on which busy is seen low.
- No combinational path from inputs to outputs.

## Configuration

- Macro: REGISTER_BANK_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed from data at store.
  - If err_inject = 1 with the store, the inverse parity bit is stored.
  - A clear writes data 0 with parity 0.
  - On load, parity_err ← (stored parity ≠ XOR of stored data). It is valid with rd_valid and is otherwise 0.
- Undefined:
  - No parity storage.
  - err_inject is ignored.
  - parity_err is tied to 0.
  - Port list is unchanged.

## Test plan

- Reset check: WIDTH=8, DEPTH=16. Assert rst_n low mid-cycle, then load addr 0..15 → every read gives rd_data=0x00 with rd_valid pulsing; parity_err=0.
- Write/read: store 0xA5@3, then load@3 next cycle → rd_data=0xA5 one cycle after load. Same-cycle store 0x3C@3 with load@3 → returns 0xA5; the next load returns 0x3C.
- Clear sweep: fill all words with 0xFF, pulse clear → busy high for 16 cycles, with stores/loads during busy ignored (rd_valid=0). Afterwards all reads give 0x00.
- Clear priority and reset mid-clear:
  - clear+store 0x11@5 in the same cycle → word 5 reads 0x00.
  - rst_n low at sweep cycle 7 → busy=0 immediately and all words read 0.
- Address bound: DEPTH=10. store 0x77@12 → no word changes; load@12 → rd_data=0x00 with rd_valid=1.
- Parity (with REGISTER_BANK_PARITY_EN):
  - store 0x07@2 with err_inject=1, then load@2 → rd_data=0x07, parity_err=1.
  - store 0x07@2 without err_inject, then load@2 → parity_err=0.
  - Without the macro, both cases give parity_err=0.
